// File: rtl/regfile_writeback_if.sv
// Write-back bus: ALU/MEM result handshakes, register-file write port,
// and the two hazard-query ports used by the register-read stage.
interface regfile_writeback_if;
  // ALU result request
  logic        ALU_Valid;
  logic [4:0]  ALU_Reg;
  logic [31:0] ALU_Data;
  logic        ALU_Ready;

  // Load result request
  logic        MEM_Valid;
  logic [4:0]  MEM_Reg;
  logic [31:0] MEM_Data;
  logic        MEM_Ready;

  // Drain control
  logic        WB_Stall;

  // Register file write port
  logic        RegWrite;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;

  // Hazard queries
  logic [4:0]  Query_Reg1;
  logic [4:0]  Query_Reg2;
  logic        Pending1;
  logic        Pending2;
  logic [31:0] Fwd_Data1;
  logic [31:0] Fwd_Data2;

  // Write-back queue side
  modport slave (
    input  ALU_Valid, ALU_Reg, ALU_Data,
    output ALU_Ready,
    input  MEM_Valid, MEM_Reg, MEM_Data,
    output MEM_Ready,
    input  WB_Stall,
    output RegWrite, Write_Reg, Write_Data,
    input  Query_Reg1, Query_Reg2,
    output Pending1, Pending2, Fwd_Data1, Fwd_Data2
  );

  // Pipeline / register-file side
  modport master (
    output ALU_Valid, ALU_Reg, ALU_Data,
    input  ALU_Ready,
    output MEM_Valid, MEM_Reg, MEM_Data,
    input  MEM_Ready,
    output WB_Stall,
    input  RegWrite, Write_Reg, Write_Data,
    output Query_Reg1, Query_Reg2,
    input  Pending1, Pending2, Fwd_Data1, Fwd_Data2
  );
endinterface

// File: rtl/regfile_writeback.sv
// In-order write-back queue in front of the 32x32 register file.
// Accepts one ALU or MEM result per cycle (ALU first), retires at most one
// register write per cycle through a registered output stage, and answers
// two hazard queries with the youngest outstanding value for a register.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  regfile_writeback_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam int NUM_QUERY = 2;

  // FIFO bookkeeping
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;

  // FIFO storage; read in parallel by the hazard search, so kept in flops
  logic [4:0]  entry_reg_mem  [DEPTH];
  logic [31:0] entry_data_mem [DEPTH];

  // Registered register-file write port
  logic        wr_en_reg, wr_en_next;
  logic [4:0]  wr_addr_reg, wr_addr_next;
  logic [31:0] wr_data_reg, wr_data_next;

  // Handshake decode
  logic        alu_ready;
  logic        mem_ready;
  logic        alu_accept;
  logic        mem_accept;
  logic        push;
  logic        pop;
  logic [4:0]  push_reg;
  logic [31:0] push_data;

  // Slots ordered by age: index 0 is the head (oldest)
  logic [PTR_W-1:0] age_slot  [DEPTH];
  logic [DEPTH-1:0] age_valid;

  // Query fan-in/fan-out
  logic [4:0]  query   [NUM_QUERY];

  // ---------------------------------------------------------------------
  // Readiness and acceptance
  // ---------------------------------------------------------------------
  // Ready only reflects the registered count, so a drain on the same edge
  // never lets a request into a full queue.
  assign alu_ready  = !Reset && (count_reg < FULL_COUNT);
  assign mem_ready  = alu_ready && !bus.ALU_Valid;
  assign alu_accept = bus.ALU_Valid && alu_ready;
  assign mem_accept = bus.MEM_Valid && mem_ready;

  // Select the accepted request; r0 completes the handshake but is dropped
  always_comb begin
    push_reg  = 5'd0;
    push_data = 32'd0;
    if (alu_accept) begin
      push_reg  = bus.ALU_Reg;
      push_data = bus.ALU_Data;
    end else if (mem_accept) begin
      push_reg  = bus.MEM_Reg;
      push_data = bus.MEM_Data;
    end
  end

  assign push = (alu_accept || mem_accept) && (push_reg != 5'd0);
  assign pop  = (count_reg != '0) && !bus.WB_Stall;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // Pointer, count and output-stage updates for this edge
  always_comb begin
    count_next   = count_reg;
    head_next    = head_reg;
    tail_next    = tail_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;

    if (push) begin
      tail_next = tail_reg + 1'b1;
    end

    if (pop) begin
      head_next    = head_reg + 1'b1;
      wr_en_next   = 1'b1;
      wr_addr_next = entry_reg_mem[head_reg];
      wr_data_next = entry_data_mem[head_reg];
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // Control state and write port; reset wins over any accept or drain
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_reg   <= '0;
      head_reg    <= '0;
      tail_reg    <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= 5'd0;
      wr_data_reg <= 32'd0;
    end else begin
      count_reg   <= count_next;
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Entry storage; stale contents are harmless once the pointers reset
  always_ff @(posedge Clk) begin
    if (push) begin
      entry_reg_mem[tail_reg]  <= push_reg;
      entry_data_mem[tail_reg] <= push_data;
    end
  end

  // ---------------------------------------------------------------------
  // Hazard search
  // ---------------------------------------------------------------------
  genvar gi;

  // Map each age position to its physical slot and validity
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_slot[gi]  = head_reg + PTR_W'(gi);
      assign age_valid[gi] = count_reg > CNT_W'(gi);
    end
  endgenerate

  assign query[0] = bus.Query_Reg1;
  assign query[1] = bus.Query_Reg2;

  generate
    for (gi = 0; gi < NUM_QUERY; gi++) begin : g_query
      logic        pend_q;
      logic [31:0] fwd_q;

      // Oldest to youngest so the youngest match overrides; the output
      // stage is older than every queued entry.
      always_comb begin
        pend_q = 1'b0;
        fwd_q  = 32'd0;
        if (wr_en_reg && (wr_addr_reg == query[gi])) begin
          pend_q = 1'b1;
          fwd_q  = wr_data_reg;
        end
        for (int k = 0; k < DEPTH; k++) begin
          if (age_valid[k] && (entry_reg_mem[age_slot[k]] == query[gi])) begin
            pend_q = 1'b1;
            fwd_q  = entry_data_mem[age_slot[k]];
          end
        end
        if (Reset || (query[gi] == 5'd0)) begin
          pend_q = 1'b0;
          fwd_q  = 32'd0;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.ALU_Ready  = alu_ready;
  assign bus.MEM_Ready  = mem_ready;
  assign bus.RegWrite   = wr_en_reg;
  assign bus.Write_Reg  = wr_addr_reg;
  assign bus.Write_Data = wr_data_reg;
  assign bus.Pending1   = g_query[0].pend_q;
  assign bus.Fwd_Data1  = g_query[0].fwd_q;
  assign bus.Pending2   = g_query[1].pend_q;
  assign bus.Fwd_Data2  = g_query[1].fwd_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: vector table for readiness and hazard
// queries, hand-written sequences for reset and latency, and a queue
// scoreboard that checks every register write in retirement order.
module tb_regfile_writeback;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  regfile_writeback_if bus ();

  regfile_writeback #(.DEPTH(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  wb_t sb[$];

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        st;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_ar;
    logic        e_mr;
    logic        e_p1;
    logic [31:0] e_f1;
    logic        e_p2;
    logic [31:0] e_f2;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic mv, input logic [4:0] mr, input logic [31:0] md,
    input logic st, input logic [4:0] q1, input logic [4:0] q2,
    input logic e_ar, input logic e_mr,
    input logic e_p1, input logic [31:0] e_f1,
    input logic e_p2, input logic [31:0] e_f2);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.mv = mv; v.mr = mr; v.md = md;
    v.st = st; v.q1 = q1; v.q2 = q2;
    v.e_ar = e_ar; v.e_mr = e_mr;
    v.e_p1 = e_p1; v.e_f1 = e_f1;
    v.e_p2 = e_p2; v.e_f2 = e_f2;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.ALU_Valid = 1'b0;
    bus.ALU_Reg   = 5'd0;
    bus.ALU_Data  = 32'd0;
    bus.MEM_Valid = 1'b0;
    bus.MEM_Reg   = 5'd0;
    bus.MEM_Data  = 32'd0;
  endtask

  task automatic drain_wait(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      next_cycle();
      n++;
    end
    chk32(name, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: check each write cycle, then record this edge's handshake
  always @(negedge Clk) begin
    wb_t e;
    if (bus.RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write actual=r%0d/%h required=no write",
                 bus.Write_Reg, bus.Write_Data);
      end else begin
        e = sb.pop_front();
        $display("WB write r%0d = %h (expected r%0d = %h)",
                 bus.Write_Reg, bus.Write_Data, e.r, e.d);
        chk32("wb_reg", 32'(bus.Write_Reg), 32'(e.r));
        chk32("wb_data", bus.Write_Data, e.d);
      end
    end
    if (Reset === 1'b1) begin
      sb.delete();
    end else if (bus.ALU_Valid && bus.ALU_Ready) begin
      if (bus.ALU_Reg != 5'd0) sb.push_back({bus.ALU_Reg, bus.ALU_Data});
    end else if (bus.MEM_Valid && bus.MEM_Ready && bus.MEM_Reg != 5'd0) begin
      sb.push_back({bus.MEM_Reg, bus.MEM_Data});
    end
  end

  initial begin
    // Vector table; each row is held for one cycle, checked before its edge
    vecs[0]  = mk(1, 1, 32'h101, 1, 2, 32'h202, 1, 1, 2, 1, 0, 0, 32'h0,   0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,   1, 2, 32'h202, 1, 1, 2, 1, 1, 1, 32'h101, 0, 32'h0);
    vecs[2]  = mk(1, 3, 32'h303, 0, 0, 32'h0,   1, 2, 3, 1, 0, 1, 32'h202, 0, 32'h0);
    vecs[3]  = mk(1, 1, 32'h111, 0, 0, 32'h0,   1, 1, 0, 1, 0, 1, 32'h101, 0, 32'h0);
    vecs[4]  = mk(1, 4, 32'h404, 1, 5, 32'h505, 1, 1, 3, 0, 0, 1, 32'h111, 1, 32'h303);
    vecs[5]  = mk(1, 4, 32'h404, 1, 5, 32'h505, 0, 1, 2, 0, 0, 1, 32'h111, 1, 32'h202);
    vecs[6]  = mk(1, 4, 32'h404, 1, 5, 32'h505, 0, 1, 2, 1, 0, 1, 32'h111, 1, 32'h202);
    vecs[7]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 2, 4, 1, 1, 1, 32'h202, 1, 32'h404);
    vecs[8]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 3, 2, 1, 1, 1, 32'h303, 0, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,   1, 0, 32'hDEAD, 1, 3, 1, 1, 1, 0, 32'h0,  1, 32'h111);
    vecs[10] = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 4, 0, 1, 1, 1, 32'h404, 0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 4, 1, 1, 1, 32'h111, 1, 32'h404);
    vecs[12] = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 4, 1, 1, 1, 1, 32'h404, 0, 32'h0);
    vecs[13] = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 4, 1, 1, 1, 0, 32'h0,   0, 32'h0);

    // Reset with requests offered: everything reads 0
    Reset          = 1'b1;
    bus.ALU_Valid  = 1'b1;
    bus.ALU_Reg    = 5'd5;
    bus.ALU_Data   = 32'h1234;
    bus.MEM_Valid  = 1'b1;
    bus.MEM_Reg    = 5'd6;
    bus.MEM_Data   = 32'h1;
    bus.WB_Stall   = 1'b0;
    bus.Query_Reg1 = 5'd5;
    bus.Query_Reg2 = 5'd6;
    next_cycle();
    @(negedge Clk);
    chk1("rst_alu_ready", bus.ALU_Ready, 1'b0);
    chk1("rst_mem_ready", bus.MEM_Ready, 1'b0);
    chk1("rst_pending1", bus.Pending1, 1'b0);
    chk1("rst_pending2", bus.Pending2, 1'b0);
    chk32("rst_fwd1", bus.Fwd_Data1, 32'h0);
    chk1("rst_regwrite", bus.RegWrite, 1'b0);
    chk32("rst_write_reg", 32'(bus.Write_Reg), 32'h0);
    chk32("rst_write_data", bus.Write_Data, 32'h0);
    next_cycle();
    Reset = 1'b0;
    idle();

    // Two-edge latency, single write cycle, held write address/data
    bus.ALU_Valid = 1'b1;
    bus.ALU_Reg   = 5'd5;
    bus.ALU_Data  = 32'h1234;
    @(negedge Clk);
    chk1("lat_ready", bus.ALU_Ready, 1'b1);
    next_cycle();
    idle();
    @(negedge Clk);
    chk1("lat_n0_regwrite", bus.RegWrite, 1'b0);
    chk1("lat_n0_pending", bus.Pending1, 1'b1);
    chk32("lat_n0_fwd", bus.Fwd_Data1, 32'h1234);
    next_cycle();
    @(negedge Clk);
    chk1("lat_n1_regwrite", bus.RegWrite, 1'b1);
    chk32("lat_n1_write_reg", 32'(bus.Write_Reg), 32'd5);
    chk32("lat_n1_write_data", bus.Write_Data, 32'h1234);
    next_cycle();
    @(negedge Clk);
    chk1("lat_n2_regwrite", bus.RegWrite, 1'b0);
    chk32("lat_n2_write_reg_hold", 32'(bus.Write_Reg), 32'd5);
    chk32("lat_n2_write_data_hold", bus.Write_Data, 32'h1234);
    chk1("lat_n2_pending", bus.Pending1, 1'b0);
    next_cycle();

    // Table: tie order, full queue, forwarding priority, r0 drop
    for (int i = 0; i < 14; i++) begin
      bus.ALU_Valid  = vecs[i].av;
      bus.ALU_Reg    = vecs[i].ar;
      bus.ALU_Data   = vecs[i].ad;
      bus.MEM_Valid  = vecs[i].mv;
      bus.MEM_Reg    = vecs[i].mr;
      bus.MEM_Data   = vecs[i].md;
      bus.WB_Stall   = vecs[i].st;
      bus.Query_Reg1 = vecs[i].q1;
      bus.Query_Reg2 = vecs[i].q2;
      @(negedge Clk);
      chk1($sformatf("v%0d_alu_ready", i), bus.ALU_Ready, vecs[i].e_ar);
      chk1($sformatf("v%0d_mem_ready", i), bus.MEM_Ready, vecs[i].e_mr);
      chk1($sformatf("v%0d_pending1", i), bus.Pending1, vecs[i].e_p1);
      chk32($sformatf("v%0d_fwd1", i), bus.Fwd_Data1, vecs[i].e_f1);
      chk1($sformatf("v%0d_pending2", i), bus.Pending2, vecs[i].e_p2);
      chk32($sformatf("v%0d_fwd2", i), bus.Fwd_Data2, vecs[i].e_f2);
      next_cycle();
    end
    idle();
    bus.WB_Stall = 1'b0;
    drain_wait("table_drained");

    // Reset while three entries sit behind a stall: all are discarded
    bus.WB_Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.ALU_Valid = 1'b1;
      bus.ALU_Reg   = 5'(10 + k);
      bus.ALU_Data  = 32'hA0 + 32'(k);
      next_cycle();
    end
    idle();
    bus.Query_Reg1 = 5'd10;
    bus.Query_Reg2 = 5'd12;
    @(negedge Clk);
    chk1("mid_pre_rst_pending", bus.Pending2, 1'b1);
    next_cycle();
    Reset = 1'b1;
    @(negedge Clk);
    chk1("mid_rst_alu_ready", bus.ALU_Ready, 1'b0);
    chk1("mid_rst_pending", bus.Pending1, 1'b0);
    next_cycle();
    Reset        = 1'b0;
    bus.WB_Stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk1($sformatf("post_rst%0d_regwrite", k), bus.RegWrite, 1'b0);
      chk1($sformatf("post_rst%0d_pending", k), bus.Pending1, 1'b0);
      chk1($sformatf("post_rst%0d_ready", k), bus.ALU_Ready, 1'b1);
      next_cycle();
    end

    // Fresh request after reset writes at the normal latency
    bus.ALU_Valid  = 1'b1;
    bus.ALU_Reg    = 5'd9;
    bus.ALU_Data   = 32'h5;
    bus.Query_Reg1 = 5'd9;
    next_cycle();
    idle();
    @(negedge Clk);
    chk1("r9_n0_regwrite", bus.RegWrite, 1'b0);
    chk32("r9_n0_fwd", bus.Fwd_Data1, 32'h5);
    next_cycle();
    @(negedge Clk);
    chk1("r9_n1_regwrite", bus.RegWrite, 1'b1);
    chk32("r9_n1_write_reg", 32'(bus.Write_Reg), 32'd9);
    chk32("r9_n1_write_data", bus.Write_Data, 32'h5);
    next_cycle();
    @(negedge Clk);
    chk1("r9_n2_regwrite", bus.RegWrite, 1'b0);
    drain_wait("final_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
